wire_test_seq: RTL and testbench



---
 rtl/wire_test_seq.sv | 126 ++++++++++++
 tb/tb_wire_test_seq.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/wire_test_seq.sv
// wire_test_seq: drives a Gray-code walk over an N-channel wire bundle and
// checks the looped-back response after a fixed latency, counting mismatches.
module wire_test_seq #(
    parameter int unsigned     WIDTH   = 2,
    parameter int unsigned     HOLD    = 20,
    parameter int unsigned     LAT     = 1,
    parameter logic [WIDTH-1:0] EXP_XOR = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] resp,
    output logic [WIDTH-1:0] stim,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [15:0]      err_count,
    output logic [7:0]       first_fail_step,
    output logic [7:0]       step_idx
);

    localparam int unsigned SW = WIDTH + 1;
    localparam int unsigned CW = 16;
    localparam logic [SW-1:0] LAST_STEP = SW'(2 ** WIDTH);
    localparam logic [CW-1:0] HOLD_M1   = CW'(HOLD - 1);
    localparam logic [CW:0]   LAT_W     = (CW + 1)'(LAT);
    localparam logic [15:0]   ERR_MAX   = 16'hFFFF;
    localparam logic [7:0]    NO_FAIL   = 8'hFF;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]       state, state_nxt;
    logic [CW-1:0]    cnt, cnt_nxt;
    logic [SW-1:0]    step, step_nxt;
    logic [WIDTH-1:0] stim_nxt;
    logic             busy_nxt, done_nxt;
    logic [15:0]      err_nxt;
    logic [7:0]       ffs_nxt;
    logic             cmp_en_c;

    // Gray code of the step index taken modulo 2^WIDTH, so the final step
    // (index 2^WIDTH) maps to the all-zero return step.
    function automatic logic [WIDTH-1:0] gray(input logic [SW-1:0] s);
        logic [WIDTH-1:0] t;
        t = WIDTH'(s);
        return t ^ (t >> 1);
    endfunction

    // Compare window opens LAT cycles into each step.
    assign cmp_en_c = (((CW + 1)'(cnt) + (CW + 1)'(1)) > LAT_W);

    // Next-state, step timing, compare and output next values.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        step_nxt  = step;
        err_nxt   = err_count;
        ffs_nxt   = first_fail_step;
        case (state)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_nxt = S_RUN;
                    cnt_nxt   = '0;
                    step_nxt  = '0;
                    err_nxt   = '0;
                    ffs_nxt   = NO_FAIL;
                end
            end
            S_RUN: begin
                if (cnt == HOLD_M1) begin
                    cnt_nxt = '0;
                    if (step == LAST_STEP) begin
                        state_nxt = S_DONE;
                    end else begin
                        step_nxt = step + SW'(1);
                    end
                end else begin
                    cnt_nxt = cnt + CW'(1);
                end
                if (cmp_en_c && (resp != (gray(step) ^ EXP_XOR))) begin
                    if (err_count != ERR_MAX) begin
                        err_nxt = err_count + 16'd1;
                    end
                    if (err_count == 16'd0) begin
                        ffs_nxt = 8'(step);
                    end
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
        busy_nxt = (state_nxt == S_RUN);
        done_nxt = (state_nxt == S_DONE);
        stim_nxt = (state_nxt == S_RUN) ? gray(step_nxt) : '0;
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= S_IDLE;
            cnt             <= '0;
            step            <= '0;
            stim            <= '0;
            busy            <= 1'b0;
            done            <= 1'b0;
            err_count       <= '0;
            first_fail_step <= NO_FAIL;
        end else begin
            state           <= state_nxt;
            cnt             <= cnt_nxt;
            step            <= step_nxt;
            stim            <= stim_nxt;
            busy            <= busy_nxt;
            done            <= done_nxt;
            err_count       <= err_nxt;
            first_fail_step <= ffs_nxt;
        end
    end

    assign pass     = done & (err_count == 16'd0);
    assign step_idx = 8'(step);

endmodule

// File: tb/tb_wire_test_seq.sv
// Testbench for wire_test_seq: scoreboard of expected stimulus per RUN cycle
// plus end-of-run result checks, on a 2-channel and two 8-channel instances.
module tb_wire_test_seq;

    localparam int unsigned RUNLEN = 100;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        start;
    logic [1:0]  stuck_mask;
    logic [1:0]  resp_d;
    logic [1:0]  resp;
    logic [1:0]  stim;
    logic        busy, done, pass;
    logic [15:0] err_count;
    logic [7:0]  first_fail_step, step_idx;

    // Wire-under-test model: one-cycle delay with optional stuck-at-0 lanes.
    always @(posedge clk) resp_d <= stim;
    assign resp = resp_d & ~stuck_mask;

    wire_test_seq #(.WIDTH(2), .HOLD(20), .LAT(1), .EXP_XOR(2'b00)) u_dut (
        .clk(clk), .rst(rst), .start(start), .resp(resp), .stim(stim),
        .busy(busy), .done(done), .pass(pass), .err_count(err_count),
        .first_fail_step(first_fail_step), .step_idx(step_idx)
    );

    logic        start_w;
    logic [7:0]  stim_s, stim_i, resp_s, resp_i;
    logic        busy_s, done_s, pass_s, busy_i, done_i, pass_i;
    logic [15:0] err_s, err_i;
    logic [7:0]  ffs_s, ffs_i, step_s, step_i;

    // Inverting wires, combinational.
    assign resp_s = ~stim_s;
    assign resp_i = ~stim_i;

    wire_test_seq #(.WIDTH(8), .HOLD(256), .LAT(0), .EXP_XOR(8'h00)) u_sat (
        .clk(clk), .rst(rst), .start(start_w), .resp(resp_s), .stim(stim_s),
        .busy(busy_s), .done(done_s), .pass(pass_s), .err_count(err_s),
        .first_fail_step(ffs_s), .step_idx(step_s)
    );

    wire_test_seq #(.WIDTH(8), .HOLD(256), .LAT(0), .EXP_XOR(8'hFF)) u_inv (
        .clk(clk), .rst(rst), .start(start_w), .resp(resp_i), .stim(stim_i),
        .busy(busy_i), .done(done_i), .pass(pass_i), .err_count(err_i),
        .first_fail_step(ffs_i), .step_idx(step_i)
    );

    int n_checks = 0;
    int n_fail   = 0;
    logic [1:0] exp_q[$];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expected stim for every cycle of a 2-channel run.
    task automatic push_run();
        logic [1:0] tab [5];
        tab = '{2'b00, 2'b01, 2'b11, 2'b10, 2'b00};
        for (int s = 0; s < 5; s++)
            for (int c = 0; c < 20; c++)
                exp_q.push_back(tab[s]);
    endtask

    // Pop and compare stim/busy for n RUN cycles.
    task automatic run_cycles(input int n, input string tag);
        logic [1:0] e;
        for (int i = 0; i < n; i++) begin
            if (exp_q.size() == 0) begin
                n_checks++; n_fail++;
                $display("FAIL %s scoreboard empty at cycle %0d", tag, i);
                e = 2'b00;
            end else begin
                e = exp_q.pop_front();
            end
            n_checks++;
            if (stim !== e || busy !== 1'b1) begin
                n_fail++;
                $display("FAIL %s cycle %0d: stim=%b busy=%b, required stim=%b busy=1",
                         tag, i, stim, busy, e);
            end
            tick();
        end
    endtask

    task automatic test_reset();
        logic [36:0] obs, exp;
        rst = 1'b1; start = 1'b1; start_w = 1'b0; stuck_mask = 2'b00;
        tick(); tick();
        obs = {stim, busy, done, pass, err_count, first_fail_step, step_idx};
        exp = {2'b00, 1'b0, 1'b0, 1'b0, 16'h0000, 8'hFF, 8'h00};
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL reset_state: got %h required %h", obs, exp);
        end
        rst = 1'b0; start = 1'b0;
        tick();
        n_checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_after_reset: busy=%b done=%b required 0 0", busy, done);
        end
    endtask

    task automatic do_full_run(input logic [1:0] mask, input string tag,
                               input logic [15:0] exp_err, input logic [7:0] exp_ffs);
        logic [28:0] obs, exp;
        stuck_mask = mask;
        start = 1'b1; tick(); start = 1'b0;
        push_run();
        run_cycles(RUNLEN, tag);
        obs = {busy, done, pass, err_count, first_fail_step, step_idx[1:0]};
        exp = {1'b0, 1'b1, (exp_err == 16'd0), exp_err, exp_ffs, 2'b00};
        n_checks++;
        if (obs !== exp || step_idx !== 8'd4) begin
            n_fail++;
            $display("FAIL %s result: busy/done/pass/err/ffs/step=%b/%b/%b/%0d/%h/%0d required %b/%b/%b/%0d/%h/4",
                     tag, busy, done, pass, err_count, first_fail_step, step_idx,
                     exp[28], exp[27], exp[26], exp_err, exp_ffs);
        end
    endtask

    task automatic test_baseline();
        do_full_run(2'b00, "baseline", 16'd0, 8'hFF);
        tick(); tick(); tick();
        n_checks++;
        if (done !== 1'b1 || pass !== 1'b1 || stim !== 2'b00 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL done_hold: done=%b pass=%b stim=%b busy=%b required 1 1 00 0",
                     done, pass, stim, busy);
        end
    endtask

    task automatic test_stuck();
        do_full_run(2'b10, "stuck_at0", 16'd38, 8'd2);
    endtask

    task automatic test_reset_mid();
        logic [36:0] obs, exp;
        stuck_mask = 2'b10;
        start = 1'b1; tick(); start = 1'b0;
        push_run();
        run_cycles(45, "pre_reset");
        n_checks++;
        if (err_count === 16'd0) begin
            n_fail++;
            $display("FAIL pre_reset_errs: err_count=%0d required nonzero", err_count);
        end
        rst = 1'b1; start = 1'b1;
        tick();
        rst = 1'b0; start = 1'b0;
        exp_q.delete();
        obs = {stim, busy, done, pass, err_count, first_fail_step, step_idx};
        exp = {2'b00, 1'b0, 1'b0, 1'b0, 16'h0000, 8'hFF, 8'h00};
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL mid_reset: got %h required %h", obs, exp);
        end
        tick();
        do_full_run(2'b00, "after_reset", 16'd0, 8'hFF);
    endtask

    task automatic test_start_held();
        logic [28:0] obs, exp;
        stuck_mask = 2'b10;
        start = 1'b1; tick();
        push_run();
        run_cycles(RUNLEN, "start_held");
        n_checks++;
        if (done !== 1'b1 || busy !== 1'b0 || err_count !== 16'd38) begin
            n_fail++;
            $display("FAIL held_done: done=%b busy=%b err=%0d required 1 0 38",
                     done, busy, err_count);
        end
        tick();
        obs = {busy, done, pass, err_count, first_fail_step, stim};
        exp = {1'b1, 1'b0, 1'b0, 16'h0000, 8'hFF, 2'b00};
        n_checks++;
        if (obs !== exp || step_idx !== 8'd0) begin
            n_fail++;
            $display("FAIL restart: got %h step=%0d required %h step=0", obs, step_idx, exp);
        end
        start = 1'b0;
        rst = 1'b1; tick(); rst = 1'b0; tick();
    endtask

    task automatic test_invert();
        int k, busy_cnt;
        logic [8:0] s9;
        logic [7:0] g;
        start_w = 1'b1; tick(); start_w = 1'b0;
        k = 0; busy_cnt = 0;
        while (!(done_s && done_i) && k < 70000) begin
            if (busy_i) busy_cnt++;
            if (k % 256 == 128) begin
                s9 = 9'(k / 256);
                g  = (s9 == 9'd256) ? 8'h00 : 8'(s9 ^ (s9 >> 1));
                n_checks++;
                if (stim_s !== g || stim_i !== g) begin
                    n_fail++;
                    $display("FAIL w8_stim step %0d: sat=%h inv=%h required %h",
                             s9, stim_s, stim_i, g);
                end
            end
            tick();
            k++;
        end
        n_checks++;
        if (!(done_s && done_i)) begin
            n_fail++;
            $display("FAIL w8_timeout: done_s=%b done_i=%b after %0d cycles", done_s, done_i, k);
        end
        n_checks++;
        if (busy_cnt != 257 * 256) begin
            n_fail++;
            $display("FAIL w8_busy_len: %0d cycles required %0d", busy_cnt, 257 * 256);
        end
        n_checks++;
        if (err_s !== 16'hFFFF || ffs_s !== 8'h00 || pass_s !== 1'b0) begin
            n_fail++;
            $display("FAIL w8_saturate: err=%h ffs=%h pass=%b required FFFF 00 0",
                     err_s, ffs_s, pass_s);
        end
        n_checks++;
        if (err_i !== 16'h0000 || ffs_i !== 8'hFF || pass_i !== 1'b1) begin
            n_fail++;
            $display("FAIL w8_inverted_pass: err=%h ffs=%h pass=%b required 0000 FF 1",
                     err_i, ffs_i, pass_i);
        end
    endtask

    initial begin
        test_reset();
        test_baseline();
        test_stuck();
        test_reset_mid();
        test_start_held();
        test_invert();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
